// File: rtl/pattern_detector_pkg.sv
// Shared constants and helpers for the serial pattern detector.
package pattern_detector_pkg;

  localparam bit MODE_OVERLAP    = 1'b1;
  localparam bit MODE_NONOVERLAP = 1'b0;

  function automatic int fill_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         Reset,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (Reset)
      q <= '0;
    else if (inc && (q != '1))
      q <= q + W'(1);
  end

endmodule

// File: rtl/pattern_detector.sv
// Parametrised Moore serial pattern detector with
// overlap/non-overlap modes and a saturating match counter.
module pattern_detector
  import pattern_detector_pkg::*;
#(
  parameter int             N       = 4,
  parameter logic [N-1:0]   PATTERN = 4'b1011,
  parameter bit             OVERLAP = MODE_OVERLAP,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             en,
  input  logic             w,
  output logic             z,
  output logic [CNT_W-1:0] count
);

  localparam int FW = fill_w(N);
  localparam logic [FW-1:0] FULL = FW'(N);

  logic [N-1:0]  hist;
  logic [N-1:0]  hist_next;
  logic [FW-1:0] fill;
  logic [FW-1:0] fill_next;
  logic          match;

  always_comb begin
    hist_next = {hist[N-2:0], w};
    fill_next = (fill == FULL) ? fill : fill + FW'(1);
    match     = en && (fill_next == FULL) && (hist_next == PATTERN);
  end

  // fill gates every match, so clearing it alone restarts detection
  always_ff @(posedge clk) begin
    if (Reset) begin
      hist <= '0;
      fill <= '0;
      z    <= 1'b0;
    end else begin
      z <= match;
      if (en) begin
        hist <= hist_next;
        if (match && (OVERLAP == MODE_NONOVERLAP))
          fill <= '0;
        else
          fill <= fill_next;
      end
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .Reset(Reset),
    .inc  (match),
    .q    (count)
  );

endmodule

// File: tb/tb_pattern_detector.sv
// Directed bench for pattern_detector: overlap, non-overlap
// and saturating configurations driven from one stimulus.
module tb_pattern_detector;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic       w   = 1'b0;
  logic       z_ov, z_no, z_sat;
  logic [7:0] cnt_ov, cnt_no;
  logic [1:0] cnt_sat;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pattern_detector #(
    .N(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)
  ) u_ov (
    .clk(clk), .Reset(rst), .en(en), .w(w),
    .z(z_ov), .count(cnt_ov)
  );

  pattern_detector #(
    .N(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)
  ) u_no (
    .clk(clk), .Reset(rst), .en(en), .w(w),
    .z(z_no), .count(cnt_no)
  );

  pattern_detector #(
    .N(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .CNT_W(2)
  ) u_sat (
    .clk(clk), .Reset(rst), .en(en), .w(w),
    .z(z_sat), .count(cnt_sat)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic e, input logic b);
    en = e;
    w  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    w   = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_z", 32'(z_ov), 0);
    check("rst_cnt", 32'(cnt_ov), 0);
    check("rst_sat", 32'(cnt_sat), 0);
  endtask

  logic [6:0] stream;
  logic [6:0] exp_ov;
  logic [6:0] exp_no;
  logic [5:0] g_en, g_w, g_z;
  logic [7:0] sat_cnt [7];

  initial begin
    // basic match
    do_reset();
    send(1, 1); check("basic_z1", 32'(z_ov), 0);
    send(1, 0); check("basic_z2", 32'(z_ov), 0);
    send(1, 1); check("basic_z3", 32'(z_ov), 0);
    send(1, 1); check("basic_z4", 32'(z_ov), 1);
    check("basic_cnt", 32'(cnt_ov), 1);
    send(0, 0); check("basic_z5", 32'(z_ov), 0);
    check("basic_cnt_hold", 32'(cnt_ov), 1);

    // overlap vs non-overlap, MSB first
    stream = 7'b1011011;
    exp_ov = 7'b0001001;
    exp_no = 7'b0001000;
    do_reset();
    for (int i = 6; i >= 0; i--) begin
      send(1, stream[i]);
      check($sformatf("ov_z%0d", 7 - i), 32'(z_ov), 32'(exp_ov[i]));
      check($sformatf("no_z%0d", 7 - i), 32'(z_no), 32'(exp_no[i]));
    end
    check("ov_cnt", 32'(cnt_ov), 2);
    check("no_cnt", 32'(cnt_no), 1);

    // enable gaps
    g_en = 6'b101101;
    g_w  = 6'b100101;
    g_z  = 6'b000001;
    do_reset();
    for (int i = 5; i >= 0; i--) begin
      send(g_en[i], g_w[i]);
      check($sformatf("gap_z%0d", 6 - i), 32'(z_ov), 32'(g_z[i]));
    end
    check("gap_cnt", 32'(cnt_ov), 1);

    // reset mid-pattern
    do_reset();
    send(1, 1); send(1, 0); send(1, 1);
    check("mid_z_pre", 32'(z_ov), 0);
    do_reset();
    send(1, 1);
    check("mid_z", 32'(z_ov), 0);
    check("mid_cnt", 32'(cnt_ov), 0);
    check("mid_fill", 32'(u_ov.fill), 1);
    send(1, 0); send(1, 1); send(1, 1);
    check("mid_rematch", 32'(z_ov), 1);

    // saturation on the 1111 / CNT_W=2 instance
    sat_cnt = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd3};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      send(1, 1);
      check($sformatf("sat_z%0d", i + 1), 32'(z_sat),
            (i >= 3) ? 32'd1 : 32'd0);
      check($sformatf("sat_cnt%0d", i + 1), 32'(cnt_sat),
            32'(sat_cnt[i]));
    end

    // reset colliding with the completing bit
    do_reset();
    send(1, 1); send(1, 0); send(1, 1);
    rst = 1'b1;
    send(1, 1);
    rst = 1'b0;
    check("col_z", 32'(z_ov), 0);
    check("col_cnt", 32'(cnt_ov), 0);
    check("col_z_no", 32'(z_no), 0);
    check("col_cnt_no", 32'(cnt_no), 0);
    send(0, 0);
    check("col_z_after", 32'(z_ov), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pattern_detector.md
# pattern_detector

Parametrised Moore-style serial pattern detector, successor to the fixed 2-bit-state `w`/`z` detector FSM. It watches a 1-bit serial input `w`, qualified by a sample enable, and raises a registered one-cycle match flag `z` whenever the last N accepted bits equal a compile-time pattern. It supports overlapping and non-overlapping detection and keeps a saturating match counter. It sits in the lab datapath wherever a hard-coded sequence FSM was previously used.

## Interface
- `N`, default 4: pattern length in bits; legal range 2..32.
- `PATTERN`, default 4'b1011: N-bit pattern; MSB is the first bit received.
- `OVERLAP`, default 1: 1 = overlapping detection, 0 = non-overlapping.
- `CNT_W`, default 8: width of the match counter.
- `clk`  in  1  rising-edge clock, single clock domain.
- `Reset`  in  1  reset, synchronous, active-high.
- `en`  in  1  sample strobe; `w` is accepted only on edges where `en`=1.
- `w`  in  1  serial data bit.
- `z`  out  1  match flag, registered (Moore).
- `count`  out  CNT_W  number of matches since reset, saturating.

## Operation
- State registers:
  - `hist[N-1:0]`: history of accepted bits.
  - `fill`: `$clog2(N+1)` bits, range 0..N; the number of valid history bits.
  - `z`, `count`.
- Reset (`Reset`=1 at a rising edge):
  - `hist`=0, `fill`=0, `z`=0, `count`=0.
  - Reset has priority over `en` and `w`.
- Accept (`en`=1, `Reset`=0):
  - `hist_next` = {`hist[N-2:0]`, `w`}.
  - `fill_next` = min(`fill`+1, N).
- Match condition: `match` = `en` & (`fill_next`==N) & (`hist_next`==`PATTERN`).
- On match:
  - `z` <= 1.
  - `count` <= `count`+1, saturating at 2^CNT_W−1 (it holds there and never wraps).
  - OVERLAP=1: `fill` stays N, so the bits of the completed pattern may start the next match.
  - OVERLAP=0: `fill` <= 0. The contents of `hist` are then don't-care, because `fill` gates any match.
- No accept (`en`=0):
  - `hist` and `fill` hold.
  - `z` <= 0.
  - `count` holds.
- `z` is high only in the cycle following an accepting edge that completed a match.
  - Back-to-back overlapped matches give `z` high on consecutive cycles.
- Conceptual states: FILLING (`fill`<N), ARMED (`fill`==N), MATCH (`z`=1).
  - MATCH is visible for exactly one cycle, then the block returns to ARMED (OVERLAP=1) or FILLING with `fill`=0 (OVERLAP=0).

## Timing
- Latency: the bit sampled at rising edge k (with `en`=1) that completes the pattern drives `z`=1 in the cycle after edge k, i.e. a 1-cycle registered latency. There is no combinational path from `w`/`en` to any output.
- `count` updates on the same edge as `z` rises.
- After a reset edge, all outputs read 0 in the following cycle. The first match needs at least N accepted bits.
- Reset mid-pattern discards the partial history; detection restarts from `fill`=0.
- `en` gaps of any length between accepted bits are transparent to detection.

## Structure
- Shared package / include file holds:
  - the OVERLAP mode constants (`MODE_OVERLAP`=1, `MODE_NONOVERLAP`=0);
  - the `$clog2`-based width helper for `fill`.
- Natural sub-module: `sat_counter` (parameter W; ports `clk`, `Reset`, `inc`, `q`).
  - Synchronous active-high reset, saturating increment.
  - Instantiated once, for `count`.
- The history shift register and match compare stay in `pattern_detector`.

## Test plan
All scenarios use N=4, PATTERN=1011, CNT_W=8 unless noted.
- Basic match: reset, then `w`=1,0,1,1 with `en`=1 each cycle → `z`=1 only in the cycle after the 4th bit; `count`=1.
- Overlap vs non-overlap: stream 1,0,1,1,0,1,1.
  - OVERLAP=1 → `z` pulses after bits 4 and 7; `count`=2.
  - OVERLAP=0 → single pulse after bit 4; `count`=1.
- Enable gaps: 1, (`en`=0, `w`=0), 0, 1, (`en`=0, `w`=0), 1 → one `z` pulse, only after the last accepted 1; `z`=0 during `en`=0 cycles.
- Reset mid-pattern: 1,0,1, then `Reset`=1 for one cycle, then 1 → no match; `fill`=1; `z`=0 and `count`=0 throughout.
- Saturation: PATTERN=1111, OVERLAP=1, CNT_W=2, seven consecutive 1s → `z` high for 4 consecutive cycles; `count` sequence 1,2,3,3.
- Reset/enable collision: `Reset`=1 and `en`=1 on the same edge that would complete 1011 → no match; all outputs 0 next cycle.
